// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB SRAM responder with configurable wait states and a two-cycle ERROR response.
// Optional define AHB_SRAM_PROT_EN rejects user-mode writes (HPROT[1]=0) with ERROR.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);
    localparam int WORDS = 1 << (ADDR_WIDTH - 2);
    localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                state, state_d;
    logic [1:0]            cnt, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic                  err_q;
    logic                  ready;
    logic                  accept;
    logic                  err_d;
    logic [3:0]            be;
    logic [31:0]           mem [WORDS];
    logic                  unused_ok;

    function automatic logic size_err(input logic [2:0] size, input logic [1:0] a);
        return (size > 3'b010) || (size == 3'b001 && a[0]) || (size == 3'b010 && a != 2'b00);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // A new address phase can only overlap a cycle in which this slave is ready.
    assign ready  = (state != ST_WAIT) && (state != ST_ERR1);
    assign accept = HSEL && HREADYIN && HTRANS[1] && ready;

`ifdef AHB_SRAM_PROT_EN
    assign err_d = size_err(HSIZE, HADDR[1:0]) || (HWRITE && !HPROT[1]);
`else
    assign err_d = size_err(HSIZE, HADDR[1:0]);
`endif

    assign unused_ok = &{1'b0, HBURST, HPROT, HADDR[31:ADDR_WIDTH], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                write_q <= HWRITE;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q <= HADDR[ADDR_WIDTH-1:0];
            size_q <= HSIZE;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 2'd0) state_d = ST_DATA;
                else             cnt_d   = cnt - 2'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all end in a cycle that may carry the next address phase.
                if (accept) begin
                    cnt_d = WS_LOAD;
                    if (err_d)                 state_d = ST_ERR1;
                    else if (WAIT_STATES == 0) state_d = ST_DATA;
                    else                       state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign HREADYOUT = ready;
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? 2'b01 : 2'b00;
    assign HRDATA    = (state == ST_DATA && !write_q) ? mem[addr_q[ADDR_WIDTH-1:2]] : 32'd0;

    // The write commits at the edge closing DATA, so a read phase starting there sees it.
    assign be = lane_mask(size_q, addr_q[1:0]);

    always_ff @(posedge HCLK) begin
        if (state == ST_DATA && write_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a zero-wait and a two-wait instance share one bus,
// checked against a byte-addressed reference memory model.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel2, hwrite, stall0;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] rd0, rd2;
    logic        ro0, ro2, hri0, hri2;
    logic [1:0]  rs0, rs2;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0] mdl   [2][4096];
    bit         known [2][4096];

    always #5 clk = ~clk;

    assign hri0 = ro0 & ~stall0;
    assign hri2 = ro2;

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYIN(hri0), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYIN(hri2), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2)
    );

    function automatic int ws(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic logic rdy(input int s);
        return (s == 0) ? ro0 : ro2;
    endfunction

    function automatic logic [1:0] resp(input int s);
        return (s == 0) ? rs0 : rs2;
    endfunction

    function automatic logic [31:0] rdat(input int s);
        return (s == 0) ? rd0 : rd2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic drive_addr(input int s, input bit wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] prot);
        hsel0  = (s == 0);
        hsel2  = (s == 1);
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hprot  = prot;
        hburst = 3'b000;
    endtask

    // Waits (bounded) for the ready cycle; returns the number of low-ready cycles seen.
    task automatic wait_ready(input int s, output int w, output logic [1:0] first_resp);
        w = 0;
        @(negedge clk);
        first_resp = resp(s);
        while (!rdy(s) && w < 20) begin
            w++;
            @(posedge clk); #1;
            @(negedge clk);
        end
    endtask

    // Single non-pipelined transfer, checked against the reference memory model.
    task automatic run(input int s, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] prot, input string tag,
                       output logic [31:0] rd_o);
        logic [11:0] la;
        bit          e;
        bit          all_known;
        int          ew;
        int          w;
        logic [31:0] exp_rd;
        logic [1:0]  r1;
        la = a[11:0];
        e  = (sz > 3'd2) || (sz == 3'd1 && la[0]) || (sz == 3'd2 && la[1:0] != 2'b00);
`ifdef AHB_SRAM_PROT_EN
        if (wr && !prot[1]) e = 1'b1;
`endif
        ew        = e ? 1 : ws(s);
        exp_rd    = 32'd0;
        all_known = 1'b1;
        if (!wr && !e) begin
            for (int k = 0; k < 4; k++) begin
                int b = {la[11:2], 2'b00} + k;
                exp_rd[8*k +: 8] = mdl[s][b];
                if (!known[s][b]) all_known = 1'b0;
            end
        end
        drive_addr(s, wr, a, sz, prot);
        @(posedge clk); #1;
        idle_bus();
        hwdata = wd;
        wait_ready(s, w, r1);
        rd_o = rdat(s);
        check({tag, ".waits"}, 32'(w), 32'(ew));
        check({tag, ".resp1"}, 32'(r1), e ? 32'd1 : 32'd0);
        check({tag, ".resp"}, 32'(resp(s)), e ? 32'd1 : 32'd0);
        if (all_known) check({tag, ".rdata"}, rd_o, exp_rd);
        @(posedge clk); #1;
        if (wr && !e) begin
            for (int k = 0; k < (1 << sz); k++) begin
                int b = la + k;
                mdl[s][b]   = wd[8*(b % 4) +: 8];
                known[s][b] = 1'b1;
            end
        end
    endtask

    // Word write immediately followed by a pipelined read of the same word.
    task automatic pipe(input int s, input logic [31:0] a, input logic [31:0] d, input string tag);
        int         w1, w2;
        logic [1:0] r;
        drive_addr(s, 1'b1, a, 3'd2, 4'b0011);
        @(posedge clk); #1;
        drive_addr(s, 1'b0, a, 3'd2, 4'b0011);
        hwdata = d;
        wait_ready(s, w1, r);
        @(posedge clk); #1;
        idle_bus();
        wait_ready(s, w2, r);
        check({tag, ".rdata"}, rdat(s), d);
        check({tag, ".resp"}, 32'(resp(s)), 32'd0);
        check({tag, ".waits"}, 32'(w1 + w2), 32'(2 * ws(s)));
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            mdl[s][a[11:0] + k]   = d[8*k +: 8];
            known[s][a[11:0] + k] = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          rs;
        logic [11:0] ra;
        logic [2:0]  rz;
        bit          rw;
        logic [3:0]  rp;

        rst_n  = 1'b0;
        stall0 = 1'b0;
        idle_bus();
        haddr  = 32'd0;
        hsize  = 3'd0;
        hburst = 3'd0;
        hprot  = 4'b0011;
        hwdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ready0", 32'(ro0), 32'd1);
        check("reset.resp0", 32'(rs0), 32'd0);
        check("reset.rdata0", rd0, 32'd0);
        check("reset.ready2", 32'(ro2), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait word write/read
        run(0, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 4'b0011, "ws0_wr", v);
        run(0, 1'b0, 32'h010, 3'd2, 32'h0, 4'b0011, "ws0_rd", v);
        check("ws0_rd.const", v, 32'hDEADBEEF);

        // Byte and halfword lanes
        run(0, 1'b1, 32'h020, 3'd2, 32'h00000000, 4'b0011, "lane_w", v);
        run(0, 1'b1, 32'h021, 3'd0, 32'h0000AA00, 4'b0011, "lane_b", v);
        run(0, 1'b1, 32'h022, 3'd1, 32'h55660000, 4'b0011, "lane_h", v);
        run(0, 1'b0, 32'h020, 3'd2, 32'h0, 4'b0011, "lane_rd", v);
        check("lane_rd.const", v, 32'h5566AA00);

        // Error responses leave memory untouched
        run(0, 1'b1, 32'h000, 3'd2, 32'h12345678, 4'b0011, "err_init", v);
        run(0, 1'b0, 32'h003, 3'd2, 32'h0, 4'b0011, "err_unaligned_rd", v);
        run(0, 1'b1, 32'h003, 3'd2, 32'hFFFFFFFF, 4'b0011, "err_unaligned_wr", v);
        run(0, 1'b1, 32'h000, 3'd3, 32'hFFFFFFFF, 4'b0011, "err_size", v);
        run(1, 1'b1, 32'h001, 3'd1, 32'hFFFFFFFF, 4'b0011, "err_half_ws2", v);
        run(0, 1'b0, 32'h000, 3'd2, 32'h0, 4'b0011, "err_rd", v);
        check("err_rd.const", v, 32'h12345678);

        // Protection
        run(0, 1'b1, 32'h030, 3'd2, 32'h11111111, 4'b0011, "prot_priv", v);
        run(0, 1'b1, 32'h030, 3'd2, 32'h22222222, 4'b0001, "prot_user", v);
        run(0, 1'b0, 32'h030, 3'd2, 32'h0, 4'b0001, "prot_rd", v);
`ifdef AHB_SRAM_PROT_EN
        check("prot_rd.const", v, 32'h11111111);
`else
        check("prot_rd.const", v, 32'h22222222);
`endif

        // Two wait states, then back-to-back pipelined write/read
        run(1, 1'b1, 32'h040, 3'd2, 32'hA5A55A5A, 4'b0011, "ws2_wr", v);
        run(1, 1'b0, 32'h040, 3'd2, 32'h0, 4'b0011, "ws2_rd", v);
        check("ws2_rd.const", v, 32'hA5A55A5A);
        pipe(1, 32'h044, 32'h89ABCDEF, "ws2_pipe");
        pipe(0, 32'h050, 32'h13579BDF, "ws0_pipe");

        // Bus stalled by another slave: no capture, no state change
        run(0, 1'b1, 32'h060, 3'd2, 32'h0BADF00D, 4'b0011, "stall_init", v);
        stall0 = 1'b1;
        drive_addr(0, 1'b1, 32'h060, 3'd2, 4'b0011);
        hwdata = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall.ready", 32'(ro0), 32'd1);
            check("stall.resp", 32'(rs0), 32'd0);
        end
        @(posedge clk); #1;
        idle_bus();
        stall0 = 1'b0;
        @(posedge clk); #1;
        run(0, 1'b0, 32'h060, 3'd2, 32'h0, 4'b0011, "stall_rd", v);
        check("stall_rd.const", v, 32'h0BADF00D);

        // Asynchronous reset during a wait state drops the in-flight write
        run(1, 1'b1, 32'h080, 3'd2, 32'hCAFEF00D, 4'b0011, "rst_init", v);
        drive_addr(1, 1'b1, 32'h080, 3'd2, 4'b0011);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 32'h11111111;
        @(negedge clk);
        check("rst.inwait", 32'(ro2), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst.ready", 32'(ro2), 32'd1);
        check("rst.resp", 32'(rs2), 32'd0);
        check("rst.rdata", rd2, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1, 1'b0, 32'h080, 3'd2, 32'h0, 4'b0011, "rst_rd", v);
        check("rst_rd.const", v, 32'hCAFEF00D);

        // Randomized traffic over a preloaded region
        for (int i = 0; i < 16; i++) begin
            run(0, 1'b1, 32'h100 + 4 * i, 3'd2, $urandom, 4'b0011, "rinit0", v);
            run(1, 1'b1, 32'h100 + 4 * i, 3'd2, $urandom, 4'b0011, "rinit2", v);
        end
        for (int i = 0; i < 80; i++) begin
            rs = $urandom_range(0, 1);
            ra = 12'h100 + 12'($urandom_range(0, 63));
            rz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (rz <= 3'd2 && $urandom_range(0, 3) != 0) ra = ra & ~12'((1 << rz) - 1);
            rw = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 4) == 0) ? 4'b0001 : 4'b0011;
            run(rs, rw, {20'($urandom), ra}, rz, $urandom, rp, "rand", v);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
